// File: rtl/e_muldiv_unit_pkg.sv
// rtl/e_muldiv_unit_pkg.sv - md_op encodings and default MULT/DIV latencies shared with the D-stage decoder
package e_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic md_is_arith(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

endpackage

// File: rtl/e_muldiv_unit_busy_ctr.sv
// rtl/e_muldiv_unit_busy_ctr.sv - loadable down-counter modelling multi-cycle MULT/DIV latency
module md_busy_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_busy,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);
  // High during the last busy cycle, so the result lands on the edge the count reaches 0
  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/e_muldiv_unit.sv
// rtl/e_muldiv_unit.sv - E-stage multiply/divide unit holding architectural HI/LO
module e_muldiv_unit
  import e_muldiv_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic             hilo_we,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [WIDTH-1:0]   r_a, r_b;
  logic [2:0]         r_op;
  logic               w_busy, w_done, w_load, w_mt;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_is_div, w_signed;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_q, w_r;

  // start beats hilo_we, and both are dropped while an op is in flight
  assign w_load     = start && !w_busy && md_is_arith(md_op);
  assign w_mt       = hilo_we && !start && !w_busy;
  assign w_load_val = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  md_busy_ctr #(.CNT_W(CNT_W)) u_busy_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  assign busy = w_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_load) begin
      r_a  <= A;
      r_b  <= B;
      r_op <= md_op;
    end
  end

  assign w_is_div = r_op[1];
  assign w_signed = !r_op[0];

  assign w_ext_a = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Sign-magnitude division: MIN/-1 falls out as MIN with remainder 0
  assign w_a_neg = w_signed && r_a[WIDTH-1];
  assign w_b_neg = w_signed && r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -r_a : r_a;
  assign w_b_mag = w_b_neg ? -r_b : r_b;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r     = w_a_neg ? -w_r_mag : w_r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (w_done) begin
      if (!w_is_div) begin
        {HI, LO} <= w_prod;
      end else if (r_b != '0) begin
        HI <= w_r;
        LO <= w_q;
      end
    end else if (w_mt) begin
      if (md_op == MD_MTHI) HI <= A;
      else if (md_op == MD_MTLO) LO <= A;
    end
  end

endmodule
